mc_maindec: RTL and testbench
=============================

Name: mc_maindec

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives datapath enables and mux selects.
- Produces the 3-bit aluop consumed by the downstream ALU-control decoder. It is the initiator side of the aluop/alucontrol interface.

Parameters:
- none (all encodings live in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode, instr[31:26]; stable from DECODE until next FETCH
- memready  in  1  memory access completes this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load (datapath ANDs with zero)
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- regdst  out  1  0 rt, 1 rd
- memtoreg  out  1  0 ALUOut, 1 data register
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  2  00 B, 01 constant 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- aluop  out  3  000 ADD, 001 AND, 010 OR, 011 SLT, 100 DADD, 101 SUB, 111 RTYPE
- illegal  out  1  one-cycle pulse on an unrecognised opcode

Behaviour:
- Reset and defaults:
  - Synchronous reset → state FETCH.
  - While reset is high, pcwrite, irwrite, memwrite, regwrite and branch are forced 0.
  - All other outputs take their FETCH values.
  - Any output not listed for a state is 0.
- State register is 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JEX=11, HALT=12.
  - Unused encodings → FETCH on the next edge.
- Output decode is Moore, except where gated by memready:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00; irwrite=pcwrite=memready.
    - Stay while memready=0; → DECODE when memready=1.
  - DECODE: alusrcb=11, aluop=ADD. Next state by op:
    - 100011/101011 → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 001000/001100/001101/001010/011000 → IMMEX
    - 000010 → JEX
    - else illegal=1 → FETCH, or HALT under the optional feature
  - MEMADR: alusrca=1, alusrcb=10, aluop=ADD. → MEMRD if op=100011, MEMWR if op=101011.
  - MEMRD: iord=1. Wait for memready, then → MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. → FETCH.
  - MEMWR: iord=1, memwrite=1, held until memready. → FETCH on memready.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=RTYPE. → RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. → FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1. → FETCH.
  - IMMEX: alusrca=1, alusrcb=10. aluop by op: ADDI→000, ANDI→001, ORI→010, SLTI→011, DADDI→100. → IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. → FETCH.
  - JEX: pcsrc=10, pcwrite=1. → FETCH.
- The ALU-control decoder maps aluop 101 → SUB (alucontrol 0110).
- Latency per instruction class, with zero memory wait:
  - LW 5 cycles; SW 4; R-type 4; immediate ops 4; BEQ 3; J 3.
  - Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction: abandon the instruction, no write strobe that cycle, FETCH on the next edge.
- memready is ignored in every state other than FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro MAINDEC_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE → HALT. HALT asserts no write enable and persists until reset. illegal pulses once, on the DECODE cycle.
- Undefined: illegal pulses and the FSM returns to FETCH; the instruction acts as a NOP. HALT is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - enum statetype (4-bit)
  - aluop constants ALUOP_ADD/AND/OR/SLT/DADD/SUB/RTYPE
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI, OP_J
- One sub-module, immop_dec: combinational op → aluop for IMMEX, shared with future pipelined control.

Test Plan:
- Reset held 2 cycles, memready=1 → state FETCH, all write enables 0. After release, irwrite=pcwrite=1 in the first cycle.
- op=100011, memready=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. regwrite=1 and memtoreg=1 only in cycle 5.
- op=101011, memready low 3 cycles in MEMWR → memwrite held 4 cycles, then FETCH. regwrite never asserted.
- op=001101, then 011000 → aluop=010, then aluop=100 in IMMEX. regwrite in IMMWB each time; 4 cycles per instruction.
- op=000100 → BEQEX with aluop=101, branch=1, pcsrc=01. op=000010 → JEX with pcwrite=1, pcsrc=10.
- op=111000 → illegal=1 for one cycle. Macro off: FETCH next. Macro on: HALT held 10 cycles with no write enables; reset returns to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control: FSM states, aluop codes and opcodes.
// Also used by mc_maindec and immop_dec.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        HALT    = 4'd12
    } statetype;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_AND   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;
    localparam logic [2:0] ALUOP_DADD  = 3'b100;
    localparam logic [2:0] ALUOP_SUB   = 3'b101;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_SLTI) || (op == OP_DADDI);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || is_imm_op(op);
    endfunction

endpackage

// File: rtl/immop_dec.sv
// Immediate-class opcode to aluop decode; kept separate so pipelined control can reuse it.
module immop_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output logic [2:0] aluop_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        aluop_o = ALUOP_ADD;
        case (op_i)
            OP_ANDI:  aluop_o = ALUOP_AND;
            OP_ORI:   aluop_o = ALUOP_OR;
            OP_SLTI:  aluop_o = ALUOP_SLT;
            OP_DADDI: aluop_o = ALUOP_DADD;
            default:  aluop_o = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MAINDEC_ILLEGAL_TRAP_EN to trap illegal opcodes in HALT instead of skipping them.
module mc_maindec
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       pcwrite,
    output logic       branch,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       illegal
);

    statetype   state_q, state_d, dec_state;
    logic [2:0] imm_aluop;
    logic       we_pcwrite, we_branch, we_memwrite, we_irwrite, we_regwrite;

    immop_dec u_immop_dec (
        .op_i    (op),
        .aluop_o (imm_aluop)
    );

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = memready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = MEMADR;
                else if (op == OP_RTYPE)        state_d = RTYPEEX;
                else if (op == OP_BEQ)          state_d = BEQEX;
                else if (is_imm_op(op))         state_d = IMMEX;
                else if (op == OP_J)            state_d = JEX;
`ifdef MAINDEC_ILLEGAL_TRAP_EN
                else                            state_d = HALT;
`else
                else                            state_d = FETCH;
`endif
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : ((op == OP_SW) ? MEMWR : FETCH);
            MEMRD:   state_d = memready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = memready ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BEQEX:   state_d = FETCH;
            IMMEX:   state_d = IMMWB;
            IMMWB:   state_d = FETCH;
            JEX:     state_d = FETCH;
`ifdef MAINDEC_ILLEGAL_TRAP_EN
            HALT:    state_d = HALT;
`else
            HALT:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Under reset the outputs show FETCH values with every write strobe suppressed.
    always_comb begin
        dec_state   = reset ? FETCH : state_q;
        we_pcwrite  = 1'b0;
        we_branch   = 1'b0;
        we_memwrite = 1'b0;
        we_irwrite  = 1'b0;
        we_regwrite = 1'b0;
        iord        = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_ADD;
        illegal     = 1'b0;
        case (dec_state)
            FETCH: begin
                alusrcb    = 2'b01;
                we_irwrite = memready;
                we_pcwrite = memready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = ~is_known_op(op);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg    = 1'b1;
                we_regwrite = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                we_memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
            end
            RTYPEWB: begin
                regdst      = 1'b1;
                we_regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 2'b01;
                we_branch = 1'b1;
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop;
            end
            IMMWB:   we_regwrite = 1'b1;
            JEX: begin
                pcsrc      = 2'b10;
                we_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcwrite  = we_pcwrite  & ~reset;
    assign branch   = we_branch   & ~reset;
    assign memwrite = we_memwrite & ~reset;
    assign irwrite  = we_irwrite  & ~reset;
    assign regwrite = we_regwrite & ~reset;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: directed vector table, randomized instruction stream against a
// per-instruction-class expectation model, mid-instruction reset and illegal-opcode handling.
module tb_mc_maindec;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic       mr;
        logic [5:0] op;
        ctrl_t      exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       memready = 1'b1;
    ctrl_t      act;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[40];
    int   nv = 0;
    vec_t q[$];

    logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                   6'b001100, 6'b001101, 6'b001010, 6'b011000, 6'b000010};

    always #5 clk = ~clk;

    mc_maindec dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .pcwrite  (act.pcwrite),
        .branch   (act.branch),
        .iord     (act.iord),
        .memwrite (act.memwrite),
        .irwrite  (act.irwrite),
        .regwrite (act.regwrite),
        .regdst   (act.regdst),
        .memtoreg (act.memtoreg),
        .alusrca  (act.alusrca),
        .alusrcb  (act.alusrcb),
        .pcsrc    (act.pcsrc),
        .aluop    (act.aluop),
        .illegal  (act.illegal)
    );

    // Expected control word for each step of an instruction, straight from the per-step table.
    function automatic ctrl_t c_zero();
        ctrl_t c;
        c = '0;
        return c;
    endfunction
    function automatic ctrl_t c_fetch(input logic mr);
        ctrl_t c = '0;
        c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr;
        return c;
    endfunction
    function automatic ctrl_t c_decode(input logic ill);
        ctrl_t c = '0;
        c.alusrcb = 2'b11; c.illegal = ill;
        return c;
    endfunction
    function automatic ctrl_t c_memadr();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t c_memrd();
        ctrl_t c = '0;
        c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memwb();
        ctrl_t c = '0;
        c.memtoreg = 1'b1; c.regwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memwr();
        ctrl_t c = '0;
        c.iord = 1'b1; c.memwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_rtex();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.aluop = 3'b111;
        return c;
    endfunction
    function automatic ctrl_t c_rtwb();
        ctrl_t c = '0;
        c.regdst = 1'b1; c.regwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_beq();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.aluop = 3'b101; c.pcsrc = 2'b01; c.branch = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_immex(input logic [2:0] a);
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = a;
        return c;
    endfunction
    function automatic ctrl_t c_immwb();
        ctrl_t c = '0;
        c.regwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_jex();
        ctrl_t c = '0;
        c.pcsrc = 2'b10; c.pcwrite = 1'b1;
        return c;
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        for (int i = 0; i < 10; i++) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input ctrl_t a, input ctrl_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, a, e);
        end
    endtask

    task automatic apply(input logic rst, input logic mr, input logic [5:0] o,
                         input ctrl_t e, input string name);
        @(negedge clk);
        reset = rst; memready = mr; op = o;
        #1;
        check(name, act, e);
    endtask

    task automatic add(input logic mr, input logic [5:0] o, input ctrl_t e, input string name);
        vecs[nv] = '{mr, o, e, name};
        nv++;
    endtask

    task automatic push(input logic mr, input logic [5:0] o, input ctrl_t e, input string name);
        vec_t v;
        v = '{mr, o, e, name};
        q.push_back(v);
    endtask

    // Reference model: expands one instruction (with fetch and memory wait counts) into its
    // cycle-by-cycle expectation; memready is randomized wherever it must be ignored.
    task automatic gen_instr(input logic [5:0] o, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(1'b0, o, c_fetch(1'b0), "rnd_fetch_wait");
        push(1'b1, o, c_fetch(1'b1), "rnd_fetch");
        push(1'($urandom), o, c_decode(!is_legal(o)), "rnd_decode");
        case (o)
            6'b100011: begin
                push(1'($urandom), o, c_memadr(), "rnd_lw_memadr");
                for (int i = 0; i < mw; i++) push(1'b0, o, c_memrd(), "rnd_memrd_wait");
                push(1'b1, o, c_memrd(), "rnd_memrd");
                push(1'($urandom), o, c_memwb(), "rnd_memwb");
            end
            6'b101011: begin
                push(1'($urandom), o, c_memadr(), "rnd_sw_memadr");
                for (int i = 0; i < mw; i++) push(1'b0, o, c_memwr(), "rnd_memwr_wait");
                push(1'b1, o, c_memwr(), "rnd_memwr");
            end
            6'b000000: begin
                push(1'($urandom), o, c_rtex(), "rnd_rtex");
                push(1'($urandom), o, c_rtwb(), "rnd_rtwb");
            end
            6'b000100: push(1'($urandom), o, c_beq(), "rnd_beq");
            6'b000010: push(1'($urandom), o, c_jex(), "rnd_jex");
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b011000: begin
                logic [2:0] a;
                a = (o == 6'b001100) ? 3'b001 : (o == 6'b001101) ? 3'b010 :
                    (o == 6'b001010) ? 3'b011 : (o == 6'b011000) ? 3'b100 : 3'b000;
                push(1'($urandom), o, c_immex(a), "rnd_immex");
                push(1'($urandom), o, c_immwb(), "rnd_immwb");
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Directed program: LW, SW with waits, ORI, DADDI, R-type, BEQ, J, illegal.
        add(1, 6'b100011, c_fetch(1),    "lw_fetch");
        add(0, 6'b100011, c_decode(0),   "lw_decode");
        add(0, 6'b100011, c_memadr(),    "lw_memadr");
        add(1, 6'b100011, c_memrd(),     "lw_memrd");
        add(0, 6'b100011, c_memwb(),     "lw_memwb");
        add(0, 6'b101011, c_fetch(0),    "sw_fetch_wait");
        add(1, 6'b101011, c_fetch(1),    "sw_fetch");
        add(1, 6'b101011, c_decode(0),   "sw_decode");
        add(1, 6'b101011, c_memadr(),    "sw_memadr");
        add(0, 6'b101011, c_memwr(),     "sw_memwr_w1");
        add(0, 6'b101011, c_memwr(),     "sw_memwr_w2");
        add(0, 6'b101011, c_memwr(),     "sw_memwr_w3");
        add(1, 6'b101011, c_memwr(),     "sw_memwr_done");
        add(1, 6'b001101, c_fetch(1),    "ori_fetch");
        add(0, 6'b001101, c_decode(0),   "ori_decode");
        add(1, 6'b001101, c_immex(3'b010), "ori_immex");
        add(0, 6'b001101, c_immwb(),     "ori_immwb");
        add(1, 6'b011000, c_fetch(1),    "daddi_fetch");
        add(1, 6'b011000, c_decode(0),   "daddi_decode");
        add(0, 6'b011000, c_immex(3'b100), "daddi_immex");
        add(1, 6'b011000, c_immwb(),     "daddi_immwb");
        add(1, 6'b000000, c_fetch(1),    "rt_fetch");
        add(0, 6'b000000, c_decode(0),   "rt_decode");
        add(1, 6'b000000, c_rtex(),      "rt_ex");
        add(0, 6'b000000, c_rtwb(),      "rt_wb");
        add(1, 6'b000100, c_fetch(1),    "beq_fetch");
        add(1, 6'b000100, c_decode(0),   "beq_decode");
        add(0, 6'b000100, c_beq(),       "beq_ex");
        add(1, 6'b000010, c_fetch(1),    "j_fetch");
        add(0, 6'b000010, c_decode(0),   "j_decode");
        add(1, 6'b000010, c_jex(),       "j_ex");
`ifndef MAINDEC_ILLEGAL_TRAP_EN
        add(1, 6'b111000, c_fetch(1),    "ill_fetch");
        add(1, 6'b111000, c_decode(1),   "ill_decode");
`endif

        apply(1, 1, 6'd0, c_fetch(0), "reset_cycle0");
        apply(1, 1, 6'd0, c_fetch(0), "reset_cycle1");
        for (int i = 0; i < nv; i++) apply(0, vecs[i].mr, vecs[i].op, vecs[i].exp, vecs[i].name);

        // Randomized instruction stream; illegal opcodes only when they do not trap.
        for (int n = 0; n < 150; n++) begin
            logic [5:0] o;
            o = legal_ops[$urandom_range(0, 9)];
`ifndef MAINDEC_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                do o = 6'($urandom); while (is_legal(o));
            end
`endif
            gen_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
            while (q.size() > 0) begin
                vec_t v;
                v = q.pop_front();
                apply(0, v.mr, v.op, v.exp, v.name);
            end
        end

        // Reset arriving in MEMWB abandons the load with no register write.
        apply(0, 1, 6'b100011, c_fetch(1),  "mrst_fetch");
        apply(0, 1, 6'b100011, c_decode(0), "mrst_decode");
        apply(0, 1, 6'b100011, c_memadr(),  "mrst_memadr");
        apply(0, 1, 6'b100011, c_memrd(),   "mrst_memrd");
        apply(1, 1, 6'b100011, c_fetch(0),  "mrst_in_memwb");
        apply(0, 1, 6'b000010, c_fetch(1),  "mrst_refetch");
        apply(0, 1, 6'b000010, c_decode(0), "mrst_j_decode");
        apply(0, 1, 6'b000010, c_jex(),     "mrst_j_ex");

        // Reset arriving in MEMWR suppresses the write strobe.
        apply(0, 1, 6'b101011, c_fetch(1),  "wrst_fetch");
        apply(0, 1, 6'b101011, c_decode(0), "wrst_decode");
        apply(0, 1, 6'b101011, c_memadr(),  "wrst_memadr");
        apply(1, 1, 6'b101011, c_fetch(0),  "wrst_in_memwr");
        apply(0, 0, 6'b101011, c_fetch(0),  "wrst_refetch_wait");

`ifdef MAINDEC_ILLEGAL_TRAP_EN
        apply(0, 1, 6'b111000, c_fetch(1),  "trap_fetch");
        apply(0, 1, 6'b111000, c_decode(1), "trap_decode");
        for (int i = 0; i < 10; i++) apply(0, 1'($urandom), 6'b111000, c_zero(), "trap_halt");
        apply(1, 1, 6'b111000, c_fetch(0),  "trap_reset");
        apply(0, 1, 6'b000010, c_fetch(1),  "trap_refetch");
        apply(0, 1, 6'b000010, c_decode(0), "trap_j_decode");
`else
        apply(0, 1, 6'b111000, c_fetch(1),  "nop_fetch");
        apply(0, 1, 6'b111000, c_decode(1), "nop_decode");
        apply(0, 1, 6'b000100, c_fetch(1),  "nop_next_fetch");
        apply(0, 1, 6'b000100, c_decode(0), "nop_beq_decode");
        apply(0, 1, 6'b000100, c_beq(),     "nop_beq_ex");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
